issue_scoreboard: RTL and testbench
===================================

Name: issue_scoreboard

Overview:
- Decode-to-execute issue controller for the single-issue RV32 pipeline.
- Accepts one decoded instruction per cycle: register indices plus the 10-bit control word {RegWrite, MemToReg, MemRead, MemWrite, ALUOp[3:0], ALUSrc, RWsel}.
- Holds the instruction while a RAW hazard exists against in-flight writes, or while the in-flight limit is reached; a 32-entry busy scoreboard tracks pending writes.
- Drives a registered valid/ready issue stage into execute and supports drain (fence) requests.

Parameters:
- MAX_INFLIGHT, 4, maximum issued-but-not-written-back register writers; legal range 1..15.
- CNT_W, 4, width of inflight count; must hold MAX_INFLIGHT.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- id_valid  in  1  decode holds an instruction
- id_ready  out  1  issue accepts the decode instruction this cycle
- id_rs1, id_rs2, id_rd  in  5 each  register indices
- id_use_rs1, id_use_rs2  in  1 each  source operand is actually read
- id_ctrl  in  10  control word; bit 9 = RegWrite
- id_drain  in  1  fence: instruction may not issue until inflight==0
- flush  in  1  discard the decode instruction and the issue register contents
- ex_ready  in  1  execute accepts the issue register
- issue_valid  out  1  issue register valid
- issue_rd  out  5  issued rd
- issue_ctrl  out  10  issued control word
- wb_valid  in  1  writeback completes
- wb_rd  in  5  writeback destination
- inflight  out  CNT_W  outstanding writer count
- busy  out  32  scoreboard bits; bit 0 is always 0

Behaviour:
- Reset (asynchronous, active-high): issue_valid=0, issue_rd=0, issue_ctrl=0, busy=0, inflight=0, state=RUN.
- Writer: RegWrite=1 and id_rd!=0.
- hazard = (id_use_rs1 & busy[id_rs1]) | (id_use_rs2 & busy[id_rs2]). Index 0 never contributes.
- full = writer & (inflight==MAX_INFLIGHT).
- drain_block = id_drain & (inflight!=0).
- can_issue = id_valid & ~hazard & ~full & ~drain_block & ~flush & (~issue_valid | ex_ready).
- id_ready is combinational and equals can_issue.
- Accept: on can_issue, the issue register loads rd and ctrl next edge; issue_valid=1. Latency is 1 cycle from decode to issue.
- Hold: if issue_valid & ~ex_ready, the issue register holds stable.
- Clear: if issue_valid & ex_ready & ~can_issue, issue_valid goes to 0.
- Scoreboard on accept of a writer: busy[id_rd] is set and inflight increments.
- Scoreboard on wb_valid & wb_rd!=0: busy[wb_rd] clears and inflight decrements.
- Same-cycle set and clear of the same rd: set wins; inflight is unchanged net.
- wb_valid with wb_rd==0 is ignored.
- Inflight never wraps. Increment while at MAX_INFLIGHT, or decrement at 0, is an illegal case and raises an assertion in simulation.
- flush: issue_valid clears next edge; id_ready=0 that cycle. Scoreboard is untouched, because writers already accepted are in execute and will write back.
- FSM, reported for debug and counters:
  - RUN: default.
  - STALL_RAW when id_valid & hazard.
  - STALL_FULL when id_valid & full & ~hazard.
  - DRAIN when id_valid & drain_block.
  - Priority: RAW > FULL > DRAIN.
  - Return to RUN when the condition clears or id_valid drops.
  - flush forces RUN.
- Back-to-back dependent instructions stall until wb_valid for the producer; no forwarding is assumed.
- Reset mid-operation: all state clears immediately; pending writebacks after reset are ignored only if busy=0 and inflight=0 (decrement saturates to 0).

Optional Feature:
- ISSUE_STALL_CNT_EN:
  - Adds outputs stall_raw_cnt and stall_full_cnt, 32 bits each.
  - Each increments on every cycle in the matching state, saturates at all-ones, and resets to 0.
- Without the macro, the ports and counters are absent.

Decomposition:
- Shared package: control-word bit positions (REGWRITE_BIT=9 etc.), the state enum {RUN, STALL_RAW, STALL_FULL, DRAIN}, and the 10-bit control-word type.
- Sub-module: reg_scoreboard (busy vector, set/clear with set priority, inflight counter); issue_scoreboard instantiates it plus the FSM and issue register.

Test Plan:
- RAW stall: issue ADDI x5 (writer), next SUB reads x5 → id_ready=0, state=STALL_RAW; wb_valid with wb_rd=5 → SUB issues the next cycle, busy[5] ends 0 after set/clear sequencing.
- x0 handling: writer with rd=0, then a reader of x0 → no stall, inflight stays 0, busy=0.
- Full limit: MAX_INFLIGHT=4, issue 4 independent writers with no writeback → 5th writer stalls (STALL_FULL); a store (non-writer) still issues; one wb → 5th issues.
- Backpressure: ex_ready=0 for 3 cycles with issue_valid=1 → issue_rd/issue_ctrl stable, id_ready=0; ex_ready=1 → next instruction loads.
- Same-cycle set/clear: wb_rd=7 in the same cycle a new writer to x7 is accepted → busy[7]=1, inflight unchanged.
- Drain and flush:
  - id_drain with inflight=2 → DRAIN until 2 writebacks, then issues.
  - flush asserted mid-stall → issue_valid=0, state=RUN, busy preserved.

Source files
------------

// File: rtl/issue_scoreboard_pkg.sv
// Shared definitions for the decode-to-execute issue controller: control-word
// layout, FSM state encoding and small decode helpers.
package issue_scoreboard_pkg;

    localparam int REGWRITE_BIT = 9;
    localparam int MEMTOREG_BIT = 8;
    localparam int MEMREAD_BIT  = 7;
    localparam int MEMWRITE_BIT = 6;
    localparam int ALUOP_MSB    = 5;
    localparam int ALUOP_LSB    = 2;
    localparam int ALUSRC_BIT   = 1;
    localparam int RWSEL_BIT    = 0;

    typedef logic [9:0] ctrl_t;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        STALL_RAW  = 2'd1,
        STALL_FULL = 2'd2,
        DRAIN      = 2'd3
    } issue_state_e;

    // Flat constants for the state register, kept for older consumers of the debug port
    localparam logic [1:0] ST_RUN        = RUN;
    localparam logic [1:0] ST_STALL_RAW  = STALL_RAW;
    localparam logic [1:0] ST_STALL_FULL = STALL_FULL;
    localparam logic [1:0] ST_DRAIN      = DRAIN;

    function automatic logic is_writer(input ctrl_t ctrl, input logic [4:0] rd);
        return ctrl[REGWRITE_BIT] & (rd != 5'd0);
    endfunction

endpackage

// File: rtl/issue_scoreboard_reg_scoreboard.sv
// Busy-register scoreboard: one pending bit per architectural register plus a
// saturating count of outstanding writers. A same-cycle set wins over a clear.
module reg_scoreboard
    import issue_scoreboard_pkg::*;
#(
    parameter int MAX_INFLIGHT = 4,
    parameter int CNT_W        = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set_en,
    input  logic [4:0]       set_rd,
    input  logic             clr_en,
    input  logic [4:0]       clr_rd,
    output logic [31:0]      busy,
    output logic [CNT_W-1:0] inflight
);

    logic [31:0]      busy_reg;
    logic [31:0]      busy_next;
    logic [CNT_W-1:0] inflight_reg;
    logic [CNT_W-1:0] inflight_next;
    logic             do_set;
    logic             do_clr;
    logic             at_max;
    logic             at_zero;

    assign do_set  = set_en & (set_rd != 5'd0);
    assign do_clr  = clr_en & (clr_rd != 5'd0);
    assign at_max  = (inflight_reg == CNT_W'(MAX_INFLIGHT));
    assign at_zero = (inflight_reg == '0);

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_busy
            // x0 is hard-wired idle; otherwise set beats a same-cycle clear
            assign busy_next[gi] = (gi != 0) &&
                ((do_set && (set_rd == 5'(gi))) ||
                 (busy_reg[gi] && !(do_clr && (clr_rd == 5'(gi)))));
        end
    endgenerate

    always_comb begin
        inflight_next = inflight_reg;
        if (do_set && !do_clr && !at_max) begin
            inflight_next = inflight_reg + CNT_W'(1);
        end else if (do_clr && !do_set && !at_zero) begin
            inflight_next = inflight_reg - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_reg     <= '0;
            inflight_reg <= '0;
        end else begin
            busy_reg     <= busy_next;
            inflight_reg <= inflight_next;
        end
    end

    assign busy     = busy_reg;
    assign inflight = inflight_reg;

`ifndef SYNTHESIS
    assert property (@(posedge clk) disable iff (rst) !(do_set && !do_clr && at_max));
    // A stale writeback after reset finds busy clear and is absorbed silently
    assert property (@(posedge clk) disable iff (rst)
        !(do_clr && !do_set && at_zero && busy_reg[clr_rd]));
`endif

endmodule

// File: rtl/issue_scoreboard.sv
// Single-issue decode-to-execute controller with RAW/in-flight/fence stalls.
// Optional ISSUE_STALL_CNT_EN adds saturating stall_raw_cnt/stall_full_cnt outputs.
module issue_scoreboard
    import issue_scoreboard_pkg::*;
#(
    parameter int MAX_INFLIGHT = 4,
    parameter int CNT_W        = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    output logic             id_ready,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [9:0]       id_ctrl,
    input  logic             id_drain,
    input  logic             flush,
    input  logic             ex_ready,
    output logic             issue_valid,
    output logic [4:0]       issue_rd,
    output logic [9:0]       issue_ctrl,
    input  logic             wb_valid,
    input  logic [4:0]       wb_rd,
    output logic [CNT_W-1:0] inflight,
    output logic [31:0]      busy,
    output logic [1:0]       state
`ifdef ISSUE_STALL_CNT_EN
    ,
    output logic [31:0]      stall_raw_cnt,
    output logic [31:0]      stall_full_cnt
`endif
);

    logic       writer;
    logic       hazard;
    logic       full;
    logic       drain_block;
    logic       can_issue;
    logic       issue_valid_reg;
    logic [4:0] issue_rd_reg;
    ctrl_t      issue_ctrl_reg;
    logic [1:0] state_reg;
    logic [1:0] state_next;

    assign writer      = is_writer(id_ctrl, id_rd);
    assign hazard      = (id_use_rs1 & busy[id_rs1]) | (id_use_rs2 & busy[id_rs2]);
    assign full        = writer & (inflight == CNT_W'(MAX_INFLIGHT));
    assign drain_block = id_drain & (inflight != '0);
    assign can_issue   = id_valid & ~hazard & ~full & ~drain_block & ~flush &
                         (~issue_valid_reg | ex_ready);
    assign id_ready    = can_issue;

    reg_scoreboard #(
        .MAX_INFLIGHT(MAX_INFLIGHT),
        .CNT_W       (CNT_W)
    ) u_reg_scoreboard (
        .clk     (clk),
        .rst     (rst),
        .set_en  (can_issue & writer),
        .set_rd  (id_rd),
        .clr_en  (wb_valid),
        .clr_rd  (wb_rd),
        .busy    (busy),
        .inflight(inflight)
    );

    // Flush drops the issue slot only; accepted writers still write back
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_valid_reg <= 1'b0;
            issue_rd_reg    <= '0;
            issue_ctrl_reg  <= '0;
        end else if (flush) begin
            issue_valid_reg <= 1'b0;
        end else if (can_issue) begin
            issue_valid_reg <= 1'b1;
            issue_rd_reg    <= id_rd;
            issue_ctrl_reg  <= id_ctrl;
        end else if (ex_ready) begin
            issue_valid_reg <= 1'b0;
        end
    end

    always_comb begin
        state_next = ST_RUN;
        if (flush) begin
            state_next = ST_RUN;
        end else if (id_valid & hazard) begin
            state_next = ST_STALL_RAW;
        end else if (id_valid & full) begin
            state_next = ST_STALL_FULL;
        end else if (id_valid & drain_block) begin
            state_next = ST_DRAIN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    assign issue_valid = issue_valid_reg;
    assign issue_rd    = issue_rd_reg;
    assign issue_ctrl  = issue_ctrl_reg;
    assign state       = state_reg;

`ifdef ISSUE_STALL_CNT_EN
    logic [31:0] stall_raw_cnt_reg;
    logic [31:0] stall_full_cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_raw_cnt_reg  <= '0;
            stall_full_cnt_reg <= '0;
        end else begin
            if (state_reg == ST_STALL_RAW && stall_raw_cnt_reg != '1) begin
                stall_raw_cnt_reg <= stall_raw_cnt_reg + 32'd1;
            end
            if (state_reg == ST_STALL_FULL && stall_full_cnt_reg != '1) begin
                stall_full_cnt_reg <= stall_full_cnt_reg + 32'd1;
            end
        end
    end

    assign stall_raw_cnt  = stall_raw_cnt_reg;
    assign stall_full_cnt = stall_full_cnt_reg;
`endif

endmodule

// File: tb/tb_issue_scoreboard.sv
// Randomized + directed bench for issue_scoreboard: a queue-based reference model
// predicts each issued instruction, busy/inflight, id_ready and the debug state.
module tb_issue_scoreboard;
    import issue_scoreboard_pkg::*;

    localparam int MAXI = 4;
    localparam logic [9:0] C_ADDI = 10'h202;
    localparam logic [9:0] C_SUB  = 10'h204;
    localparam logic [9:0] C_SW   = 10'h042;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_ready, id_use_rs1, id_use_rs2, id_drain, flush, ex_ready;
    logic [4:0] id_rs1, id_rs2, id_rd, issue_rd, wb_rd;
    logic [9:0] id_ctrl, issue_ctrl;
    logic       issue_valid, wb_valid;
    logic [3:0] inflight;
    logic [31:0] busy;
    logic [1:0] state;
`ifdef ISSUE_STALL_CNT_EN
    logic [31:0] stall_raw_cnt, stall_full_cnt;
    int cnt_raw_m = 0;
    int cnt_full_m = 0;
`endif

    issue_scoreboard #(.MAX_INFLIGHT(MAXI), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_ctrl(id_ctrl),
        .id_drain(id_drain), .flush(flush), .ex_ready(ex_ready),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ctrl(issue_ctrl),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .inflight(inflight), .busy(busy),
        .state(state)
`ifdef ISSUE_STALL_CNT_EN
        , .stall_raw_cnt(stall_raw_cnt), .stall_full_cnt(stall_full_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] rd;
        logic [9:0] ctrl;
    } exp_t;

    exp_t       exp_q[$];
    logic [4:0] pend_wb[$];
    logic [31:0] busy_m = '0;
    int         inflight_m = 0;
    logic [1:0] exp_state = 2'd0;
    logic       acc_now = 1'b0;
    exp_t       mon_e;
    int         checks = 0;
    int         failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // One clock of stimulus; model is evaluated mid-cycle on the driven inputs
    task automatic step(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic u1, input logic u2,
                        input logic [9:0] ctrl, input logic drn, input logic fl,
                        input logic exr, input logic wbv, input logic [4:0] wbr);
        logic wr, hz, fu, db, acc;
        logic [1:0] nst;
        exp_t e;
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_use_rs1 = u1; id_use_rs2 = u2; id_ctrl = ctrl; id_drain = drn;
        flush = fl; ex_ready = exr; wb_valid = wbv; wb_rd = wbr;
        #1;
        wr  = ctrl[9] && (rd != 5'd0);
        hz  = (u1 && busy_m[rs1]) || (u2 && busy_m[rs2]);
        fu  = wr && (inflight_m == MAXI);
        db  = drn && (inflight_m != 0);
        acc = v && !hz && !fu && !db && !fl && ((exp_q.size() == 0) || exr);
        chk("id_ready", {31'd0, id_ready}, {31'd0, acc});
        chk("busy", busy, busy_m);
        chk("inflight", {28'd0, inflight}, inflight_m);
        chk("state", {30'd0, state}, {30'd0, exp_state});
`ifdef ISSUE_STALL_CNT_EN
        chk("stall_raw_cnt", stall_raw_cnt, cnt_raw_m);
        chk("stall_full_cnt", stall_full_cnt, cnt_full_m);
        if (exp_state == 2'd1) cnt_raw_m++;
        if (exp_state == 2'd2) cnt_full_m++;
`endif
        if (fl)              nst = 2'd0;
        else if (v && hz)    nst = 2'd1;
        else if (v && fu)    nst = 2'd2;
        else if (v && db)    nst = 2'd3;
        else                 nst = 2'd0;
        exp_state = nst;
        acc_now = acc;
        if (acc) begin
            e.rd = rd; e.ctrl = ctrl;
            exp_q.push_back(e);
        end
        if (wbv && wbr != 5'd0) begin
            busy_m[wbr] = 1'b0;
            if (inflight_m > 0) inflight_m--;
            for (int i = 0; i < pend_wb.size(); i++) begin
                if (pend_wb[i] == wbr) begin
                    pend_wb.delete(i);
                    break;
                end
            end
        end
        if (acc && wr) begin
            busy_m[rd] = 1'b1;
            inflight_m++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        step(0, 0, 0, 0, 0, 0, 10'h0, 0, 0, 1, 0, 0);
    endtask

    task automatic drain_all();
        for (int i = 0; i < 300; i++) begin
            if (pend_wb.size() == 0 && exp_q.size() == 0 && inflight_m == 0) return;
            if (pend_wb.size() != 0) step(0, 0, 0, 0, 0, 0, 10'h0, 0, 0, 1, 1, pend_wb[0]);
            else nop();
        end
        chk("drain_timeout_inflight", {28'd0, inflight}, 32'd0);
    endtask

    // Monitor: the issue register must always hold the oldest predicted instruction
    always @(negedge clk) begin
        if (!rst) begin
            chk("issue_valid", {31'd0, issue_valid},
                {31'd0, (exp_q.size() > (acc_now ? 1 : 0))});
            if (issue_valid && exp_q.size() != 0) begin
                chk("issue_rd", {27'd0, issue_rd}, {27'd0, exp_q[0].rd});
                chk("issue_ctrl", {22'd0, issue_ctrl}, {22'd0, exp_q[0].ctrl});
                if (flush || ex_ready) begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.ctrl[9] && mon_e.rd != 5'd0) pend_wb.push_back(mon_e.rd);
                    $display("%s rd=%0d ctrl=%03h t=%0t", flush ? "flushed" : "issued",
                             mon_e.rd, mon_e.ctrl, $time);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        id_ctrl = 0; id_drain = 0; flush = 0; ex_ready = 0; wb_valid = 0; wb_rd = 0;
        repeat (2) @(negedge clk);
        chk("rst_issue_valid", {31'd0, issue_valid}, 32'd0);
        chk("rst_issue_rd", {27'd0, issue_rd}, 32'd0);
        chk("rst_issue_ctrl", {22'd0, issue_ctrl}, 32'd0);
        chk("rst_busy", busy, 32'd0);
        chk("rst_inflight", {28'd0, inflight}, 32'd0);
        chk("rst_state", {30'd0, state}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // RAW stall released by producer writeback
        step(1, 0, 0, 5, 0, 0, C_ADDI, 0, 0, 1, 0, 0);
        step(1, 5, 0, 6, 1, 0, C_SUB, 0, 0, 1, 0, 0);
        step(1, 5, 0, 6, 1, 0, C_SUB, 0, 0, 1, 0, 0);
        step(1, 5, 0, 6, 1, 0, C_SUB, 0, 0, 1, 1, 5);
        step(1, 5, 0, 6, 1, 0, C_SUB, 0, 0, 1, 0, 0);
        nop();
        // x0 as destination and source
        step(1, 0, 0, 0, 0, 0, C_ADDI, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 1, 1, C_SW, 0, 0, 1, 0, 0);
        drain_all();
        // in-flight limit: 5th writer stalls, store passes, one writeback frees a slot
        for (int r = 1; r <= 4; r++) step(1, 0, 0, 5'(r), 0, 0, C_ADDI, 0, 0, 1, 0, 0);
        step(1, 0, 0, 10, 0, 0, C_ADDI, 0, 0, 1, 0, 0);
        step(1, 0, 0, 10, 0, 0, C_ADDI, 0, 0, 1, 0, 0);
        step(1, 11, 12, 0, 1, 1, C_SW, 0, 0, 1, 0, 0);
        step(1, 0, 0, 10, 0, 0, C_ADDI, 0, 0, 1, 1, 1);
        step(1, 0, 0, 10, 0, 0, C_ADDI, 0, 0, 1, 0, 0);
        drain_all();
        // backpressure holds the issue register
        step(1, 0, 0, 2, 0, 0, C_ADDI, 0, 0, 0, 0, 0);
        repeat (3) step(1, 0, 0, 3, 0, 0, C_SUB, 0, 0, 0, 0, 0);
        step(1, 0, 0, 3, 0, 0, C_SUB, 0, 0, 1, 0, 0);
        drain_all();
        // same-cycle set/clear on x7
        step(1, 0, 0, 7, 0, 0, C_ADDI, 0, 0, 1, 0, 0);
        nop();
        step(1, 0, 0, 7, 0, 0, C_SUB, 0, 0, 1, 1, 7);
        nop();
        drain_all();
        // fence waits for two writers
        step(1, 0, 0, 1, 0, 0, C_ADDI, 0, 0, 1, 0, 0);
        step(1, 0, 0, 2, 0, 0, C_ADDI, 0, 0, 1, 0, 0);
        nop();
        step(1, 0, 0, 0, 0, 0, C_SW, 1, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0, C_SW, 1, 0, 1, 1, 1);
        step(1, 0, 0, 0, 0, 0, C_SW, 1, 0, 1, 1, 2);
        step(1, 0, 0, 0, 0, 0, C_SW, 1, 0, 1, 0, 0);
        drain_all();
        // flush during a RAW stall with a held issue register
        step(1, 0, 0, 4, 0, 0, C_ADDI, 0, 0, 1, 0, 0);
        step(1, 4, 0, 9, 1, 0, C_SUB, 0, 0, 0, 0, 0);
        step(1, 4, 0, 9, 1, 0, C_SUB, 0, 0, 0, 0, 0);
        step(1, 4, 0, 9, 1, 0, C_SUB, 0, 1, 0, 0, 0);
        nop();
        nop();
        drain_all();

        for (int n = 0; n < 600; n++) begin
            logic       v, u1, u2, drn, fl, exr, wbv;
            logic [4:0] rs1, rs2, rd, wbr;
            logic [9:0] ctrl;
            v    = ($urandom % 4) != 0;
            rs1  = 5'($urandom % 8);
            rs2  = 5'($urandom % 8);
            rd   = 5'($urandom % 8);
            u1   = 1'($urandom);
            u2   = 1'($urandom);
            ctrl = {(($urandom % 3) != 0), 9'($urandom)};
            drn  = ($urandom % 16) == 0;
            fl   = ($urandom % 32) == 0;
            exr  = ($urandom % 4) != 0;
            wbv  = 1'b0;
            wbr  = 5'd0;
            if (pend_wb.size() != 0 && ($urandom % 3) == 0) begin
                wbv = 1'b1;
                wbr = pend_wb[$urandom % pend_wb.size()];
            end else if (($urandom % 20) == 0) begin
                wbv = 1'b1;
            end
            step(v, rs1, rs2, rd, u1, u2, ctrl, drn, fl, exr, wbv, wbr);
        end
        drain_all();
        nop();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
